// File: rtl/alu_bist_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bist_engine_if
//  Brief    : Stimulus/response bus between the BIST engine and the 4-bit ALU.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_bist_engine_if;
    logic [3:0] dut_a;
    logic [3:0] dut_b;
    logic [2:0] dut_op;
    logic [3:0] dut_y;
    logic       dut_carry;

    // The engine is master: it drives operands and samples the result.
    modport master (
        output dut_a,
        output dut_b,
        output dut_op,
        input  dut_y,
        input  dut_carry
    );

    modport slave (
        input  dut_a,
        input  dut_b,
        input  dut_op,
        output dut_y,
        output dut_carry
    );
endinterface
`default_nettype wire

// File: rtl/alu_bist_engine.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bist_engine
//  Brief    : On-chip BIST for the 4-bit 8-op ALU: exhaustive or LFSR stimulus,
//             latency-aligned checking, mismatch count and first-fail capture.
//  Revision : 1.0  initial release
// ============================================================================
module alu_bist_engine #(
    parameter int DUT_LATENCY = 0,
    parameter int NUM_RANDOM  = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [10:0]        seed,
    alu_bist_engine_if.master  alu,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [11:0]        err_count,
    output logic [15:0]        fail_vec
);

    localparam logic [11:0] c_NUM_EXH    = 12'd2048;
    localparam logic [11:0] c_NUM_RND    = 12'(NUM_RANDOM);
    localparam logic [11:0] c_ERR_MAX    = 12'hFFF;
    localparam logic [1:0]  c_DRAIN_LAST = 2'(DUT_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_mode;
    logic [10:0] r_vec;
    logic [11:0] r_issued;
    logic [1:0]  r_drain;
    logic [11:0] r_err;
    logic [15:0] r_fail;

    logic        w_start_ok;
    logic [11:0] w_total;
    logic        w_last;
    logic [10:0] w_seed_init;
    logic [10:0] w_vec_step;

    logic        w_chk_valid;
    logic [10:0] w_chk_vec;
    logic [2:0]  w_chk_op;
    logic [3:0]  w_chk_a;
    logic [3:0]  w_chk_b;
    logic [4:0]  w_exp;
    logic        w_mismatch;

    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_total     = r_mode ? c_NUM_RND : c_NUM_EXH;
    assign w_last      = (r_state == S_RUN) && (r_issued == (w_total - 12'd1));
    assign w_seed_init = (seed == 11'd0) ? 11'h001 : seed;
    // r_vec doubles as generator state: counter in exhaustive mode, LFSR otherwise.
    assign w_vec_step  = r_mode ? {r_vec[9:0], r_vec[10] ^ r_vec[8]} : (r_vec + 11'd1);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = (DUT_LATENCY == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain == c_DRAIN_LAST) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Stimulus generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode   <= 1'b0;
            r_vec    <= 11'd0;
            r_issued <= 12'd0;
            r_drain  <= 2'd0;
        end else begin
            if (w_start_ok) begin
                r_mode   <= mode;
                r_vec    <= mode ? w_seed_init : 11'd0;
                r_issued <= 12'd0;
            end else if (r_state == S_RUN) begin
                if (w_last) begin
                    r_vec <= 11'd0;
                end else begin
                    r_vec    <= w_vec_step;
                    r_issued <= r_issued + 12'd1;
                end
            end
            r_drain <= (r_state == S_DRAIN) ? (r_drain + 2'd1) : 2'd0;
        end
    end

    assign alu.dut_op = r_vec[10:8];
    assign alu.dut_a  = r_vec[7:4];
    assign alu.dut_b  = r_vec[3:0];

    // ------------------------------------------------------------------
    // Delay line aligning each issued vector with its ALU response
    // ------------------------------------------------------------------
    generate
        if (DUT_LATENCY == 0) begin : g_lat0
            assign w_chk_valid = (r_state == S_RUN);
            assign w_chk_vec   = r_vec;
        end else begin : g_latn
            logic [10:0]            r_dl_vec [DUT_LATENCY];
            logic [DUT_LATENCY-1:0] r_dl_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dl_vld <= '0;
                    for (int i = 0; i < DUT_LATENCY; i++) begin
                        r_dl_vec[i] <= 11'd0;
                    end
                end else begin
                    r_dl_vld[0] <= (r_state == S_RUN);
                    r_dl_vec[0] <= r_vec;
                    for (int i = 1; i < DUT_LATENCY; i++) begin
                        r_dl_vld[i] <= r_dl_vld[i-1];
                        r_dl_vec[i] <= r_dl_vec[i-1];
                    end
                end
            end

            assign w_chk_valid = r_dl_vld[DUT_LATENCY-1];
            assign w_chk_vec   = r_dl_vec[DUT_LATENCY-1];
        end
    endgenerate

    assign w_chk_op = w_chk_vec[10:8];
    assign w_chk_a  = w_chk_vec[7:4];
    assign w_chk_b  = w_chk_vec[3:0];

    // ------------------------------------------------------------------
    // Golden ALU model, result packed as {carry, y}
    // ------------------------------------------------------------------
    always_comb begin
        w_exp = 5'd0;
        unique case (w_chk_op)
            3'b000:  w_exp = {1'b0, w_chk_a} + {1'b0, w_chk_b};
            3'b001:  w_exp = {(w_chk_a < w_chk_b), (w_chk_a - w_chk_b)};
            3'b010:  w_exp = {1'b0, w_chk_a & w_chk_b};
            3'b011:  w_exp = {1'b0, w_chk_a | w_chk_b};
            3'b100:  w_exp = {1'b0, w_chk_a ^ w_chk_b};
            3'b101:  w_exp = {1'b0, ~w_chk_a};
            3'b110:  w_exp = {1'b0, w_chk_a};
            default: w_exp = {1'b0, w_chk_b};
        endcase
    end

    assign w_mismatch = w_chk_valid && ({alu.dut_carry, alu.dut_y} != w_exp);

    // ------------------------------------------------------------------
    // Result collection
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 12'd0;
            r_fail <= 16'd0;
        end else if (w_start_ok) begin
            r_err  <= 12'd0;
            r_fail <= 16'd0;
        end else if (w_mismatch) begin
            if (r_err != c_ERR_MAX) begin
                r_err <= r_err + 12'd1;
            end
            // A zero count means this is the first failure since start.
            if (r_err == 12'd0) begin
                r_fail <= {w_chk_vec, alu.dut_y, alu.dut_carry};
            end
        end
    end

    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign pass      = done && (r_err == 12'd0);
    assign err_count = r_err;
    assign fail_vec  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_alu_bist_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_bist_engine
//  Brief    : Self-checking bench: three engines (latency 0/2/1) against
//             behavioural ALUs, scoreboard of predicted run outcomes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_bist_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference ALU, result packed as {carry, y}; stuck forces the add carry low.
    function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic stuck);
        int sa;
        int sb;
        logic [4:0] r;
        sa = int'(a);
        sb = int'(b);
        case (op)
            3'd0:    r = 5'(sa + sb);
            3'd1:    r = {(sa < sb), 4'(sa - sb)};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, 4'(15 - sa)};
            3'd6:    r = {1'b0, a};
            default: r = {1'b0, b};
        endcase
        if (stuck && op == 3'd0) r[4] = 1'b0;
        return r;
    endfunction

    alu_bist_engine_if if_a ();
    alu_bist_engine_if if_b ();
    alu_bist_engine_if if_c ();

    logic        start_a  = 1'b0, mode_a  = 1'b0, fault_a = 1'b0;
    logic [10:0] seed_a   = 11'd0;
    logic        start_bc = 1'b0, mode_bc = 1'b0;
    logic [10:0] seed_bc  = 11'd0;

    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
    logic [11:0] err_a, err_b, err_c;
    logic [15:0] fv_a, fv_b, fv_c;

    alu_bist_engine #(.DUT_LATENCY(0), .NUM_RANDOM(256)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .seed(seed_a), .alu(if_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .fail_vec(fv_a));

    alu_bist_engine #(.DUT_LATENCY(2), .NUM_RANDOM(256)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_bc), .mode(mode_bc), .seed(seed_bc), .alu(if_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .fail_vec(fv_b));

    alu_bist_engine #(.DUT_LATENCY(1), .NUM_RANDOM(256)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_bc), .mode(mode_bc), .seed(seed_bc), .alu(if_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .fail_vec(fv_c));

    // ALU A is combinational; ALUs B and C are piped through two registers.
    assign {if_a.dut_carry, if_a.dut_y} = alu_ref(if_a.dut_op, if_a.dut_a, if_a.dut_b, fault_a);

    logic [4:0] r_pb1 = 5'd0, r_pb2 = 5'd0, r_pc1 = 5'd0, r_pc2 = 5'd0;
    always @(posedge clk) begin
        r_pb1 <= alu_ref(if_b.dut_op, if_b.dut_a, if_b.dut_b, 1'b0);
        r_pb2 <= r_pb1;
        r_pc1 <= alu_ref(if_c.dut_op, if_c.dut_a, if_c.dut_b, 1'b0);
        r_pc2 <= r_pc1;
    end
    assign {if_b.dut_carry, if_b.dut_y} = r_pb2;
    assign {if_c.dut_carry, if_c.dut_y} = r_pc2;

    // Observation mux onto the engine under test
    int          sel = 0;
    logic [10:0] m_vec;
    logic        m_busy, m_done, m_pass;
    logic [11:0] m_err;
    logic [15:0] m_fv;
    always_comb begin
        m_vec  = {if_a.dut_op, if_a.dut_a, if_a.dut_b};
        m_busy = busy_a; m_done = done_a; m_pass = pass_a; m_err = err_a; m_fv = fv_a;
        if (sel == 1) begin
            m_vec  = {if_b.dut_op, if_b.dut_a, if_b.dut_b};
            m_busy = busy_b; m_done = done_b; m_pass = pass_b; m_err = err_b; m_fv = fv_b;
        end else if (sel == 2) begin
            m_vec  = {if_c.dut_op, if_c.dut_a, if_c.dut_b};
            m_busy = busy_c; m_done = done_c; m_pass = pass_c; m_err = err_c; m_fv = fv_c;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        int          lat;
        logic [10:0] first;
        logic [31:0] sig;
        logic [11:0] err;
        logic [15:0] fv;
    } exp_t;

    exp_t sb_q[$];

    // Predicts a whole run; lag = how many vectors behind the observed response trails.
    function automatic exp_t model_run(input logic m, input logic [10:0] sd, input int n,
                                       input int lat, input int lag, input logic stuck);
        exp_t        e;
        logic [10:0] hist [2048];
        logic [10:0] v;
        logic [10:0] ov;
        logic [4:0]  want;
        logic [4:0]  got;
        e.lat = lat; e.sig = 32'd0; e.err = 12'd0; e.fv = 16'd0;
        v = m ? ((sd == 11'd0) ? 11'h001 : sd) : 11'd0;
        e.first = v;
        for (int k = 0; k < n; k++) begin
            hist[k] = v;
            e.sig   = {e.sig[30:0], e.sig[31]} ^ {21'd0, v};
            ov      = (k >= lag) ? hist[k-lag] : 11'd0;
            want    = alu_ref(v[10:8], v[7:4], v[3:0], 1'b0);
            got     = alu_ref(ov[10:8], ov[7:4], ov[3:0], stuck);
            if (want != got) begin
                if (e.err == 12'd0) e.fv = {v, got[3:0], got[4]};
                if (e.err != 12'hFFF) e.err = e.err + 12'd1;
            end
            v = m ? {v[9:0], v[10] ^ v[8]} : (v + 11'd1);
        end
        return e;
    endfunction

    task automatic set_ctl(input int s, input logic st, input logic m, input logic [10:0] sd);
        if (s == 0) begin
            start_a = st; mode_a = m; seed_a = sd;
        end else begin
            start_bc = st; mode_bc = m; seed_bc = sd;
        end
    endtask

    task automatic run(input int s, input logic m, input logic [10:0] sd, input logic stuck,
                       input logic midstart, input int n);
        exp_t        g;
        logic [31:0] sig;
        logic [10:0] first_act;
        int          w;
        int          gaps;
        int          lat;
        lat       = (s == 0) ? 0 : ((s == 1) ? 2 : 1);
        sel       = s;
        fault_a   = stuck;
        sig       = 32'd0;
        gaps      = 0;
        first_act = 11'd0;
        sb_q.push_back(model_run(m, sd, n, lat, (s == 2) ? 1 : 0, stuck));
        set_ctl(s, 1'b1, m, sd);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            set_ctl(s, midstart && (i == 50), m, sd);
            if (i == 0) first_act = m_vec;
            sig = {sig[30:0], sig[31]} ^ {21'd0, m_vec};
            if (!m_busy || m_done) gaps++;
            @(posedge clk); #1;
        end
        set_ctl(s, 1'b0, m, sd);
        chk("vec_after_run", {21'd0, m_vec}, 32'd0);
        chk("busy_after_run", {31'd0, m_busy}, {31'd0, (lat > 0)});
        w = 0;
        while (!m_done && w < 8) begin
            @(posedge clk); #1;
            w++;
        end
        g = sb_q.pop_front();
        chk("drain_cycles", w, g.lat);
        chk("first_vec", {21'd0, first_act}, {21'd0, g.first});
        chk("vec_signature", sig, g.sig);
        chk("busy_in_run", gaps, 0);
        chk("err_count", {20'd0, m_err}, {20'd0, g.err});
        chk("fail_vec", {16'd0, m_fv}, {16'd0, g.fv});
        chk("pass", {31'd0, m_pass}, {31'd0, (g.err == 12'd0)});
        chk("busy_at_done", {31'd0, m_busy}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, m_done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, m_pass}, 32'd0);
        chk({tag, "_err"},  {20'd0, m_err},  32'd0);
        chk({tag, "_fv"},   {16'd0, m_fv},   32'd0);
        chk({tag, "_vec"},  {21'd0, m_vec},  32'd0);
    endtask

    task automatic reset_test();
        sel     = 0;
        fault_a = 1'b1;
        set_ctl(0, 1'b1, 1'b0, 11'd0);
        @(posedge clk); #1;
        set_ctl(0, 1'b0, 1'b0, 11'd0);
        repeat (100) @(posedge clk);
        #1;
        chk("pre_rst_vec", {21'd0, m_vec}, 32'd100);
        chk("pre_rst_err", {20'd0, m_err}, 32'd15);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("mid_rst");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run(0, 1'b0, 11'd0, 1'b0, 1'b0, 2048);
        run(0, 1'b0, 11'd0, 1'b1, 1'b0, 2048);
        chk("stuck_err_const", {20'd0, m_err}, 32'd120);
        chk("stuck_fv_const", {16'd0, m_fv}, 32'h03E0);
        run(0, 1'b0, 11'd0, 1'b0, 1'b0, 2048);
        run(0, 1'b1, 11'd0, 1'b0, 1'b0, 256);
        run(0, 1'b1, 11'h5A3, 1'b0, 1'b0, 256);
        reset_test();
        run(0, 1'b0, 11'd0, 1'b0, 1'b1, 2048);
        run(1, 1'b0, 11'd0, 1'b0, 1'b0, 2048);
        run(2, 1'b0, 11'd0, 1'b0, 1'b0, 2048);
        chk("lat1_err_nonzero", {31'd0, (m_err != 12'd0)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errs, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
